// File: rtl/ship_pkg.sv
// Shared types and constants for the player-shot manager.
package ship_pkg;

  localparam logic [7:0] FIRE_KEY = 8'h2C;
  localparam int         SCREEN_W = 640;
  localparam int         SCREEN_H = 480;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } shot_state_e;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } shot_t;

  // Unsigned subtract clamped at zero; positions never go negative.
  function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : 10'd0;
  endfunction

endpackage

// File: rtl/ship_shot_ctrl_if.sv
// Frame-level bus between the ship stage / collision logic and the shot manager.
interface ship_shot_ctrl_if #(
  parameter int NUM_SHOTS = 4
);
  logic [7:0]              keycode;
  logic [9:0]              ShipX;
  logic [9:0]              ShipY;
  logic [9:0]              ShipSY;
  logic                    hit_valid;
  logic [2:0]              hit_idx;
  logic [10*NUM_SHOTS-1:0] ShotX;
  logic [10*NUM_SHOTS-1:0] ShotY;
  logic [NUM_SHOTS-1:0]    ShotActive;
  logic                    fire_pulse;

  modport master (
    output keycode, ShipX, ShipY, ShipSY, hit_valid, hit_idx,
    input  ShotX, ShotY, ShotActive, fire_pulse
  );

  modport slave (
    input  keycode, ShipX, ShipY, ShipSY, hit_valid, hit_idx,
    output ShotX, ShotY, ShotActive, fire_pulse
  );
endinterface

// File: rtl/shot_slot.sv
// One shot slot: holds position and flight state, moves up each frame.
//
//   state | meaning
//   IDLE  | slot free; x/y hold the last position
//   FLY   | live shot moving up by SHOT_STEP per frame
module shot_slot
  import ship_pkg::*;
#(
  parameter int SHOT_STEP = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       i_launch,
  input  logic [9:0] i_launch_x,
  input  logic [9:0] i_launch_y,
  input  logic       i_hit,
  output shot_t      o_shot
);

  localparam logic [9:0] STEP10 = 10'(SHOT_STEP);

  shot_state_e r_state, w_state_nxt;
  logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;

  // State and position registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next state: launch from IDLE; in flight hit beats top-edge retire beats move.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    case (r_state)
      IDLE: begin
        if (i_launch) begin
          w_state_nxt = FLY;
          w_x_nxt     = i_launch_x;
          w_y_nxt     = i_launch_y;
        end
      end
      FLY: begin
        if (i_hit)              w_state_nxt = IDLE;
        else if (r_y < STEP10)  w_state_nxt = IDLE;
        else                    w_y_nxt     = r_y - STEP10;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_shot = '{active: (r_state == FLY), x: r_x, y: r_y};

endmodule

// File: rtl/ship_shot_ctrl.sv
// Player-shot manager: fire-key detection, launch cooldown and lowest-free-slot
// allocation over a pool of shot_slot instances.
// Build option: SHIP_SHOT_AUTOFIRE_EN makes the fire key level-sensitive.
module ship_shot_ctrl
  import ship_pkg::*;
#(
  parameter int NUM_SHOTS = 4,
  parameter int SHOT_STEP = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic              frame_clk,
  input  logic              Reset,
  ship_shot_ctrl_if.slave   bus
);

  localparam int              CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [7:0]           r_prev_key;
  logic [CD_W-1:0]      r_cooldown;
  logic                 r_fire_pulse;
  logic                 w_fire_req;
  logic                 w_launch;
  logic                 w_any_idle;
  logic [9:0]           w_launch_y;
  logic [NUM_SHOTS-1:0] w_idle;
  logic [NUM_SHOTS-1:0] w_first_idle;
  logic [NUM_SHOTS-1:0] w_launch_vec;
  logic [NUM_SHOTS-1:0] w_hit_vec;
  shot_t                w_shot [NUM_SHOTS];

`ifdef SHIP_SHOT_AUTOFIRE_EN
  assign w_fire_req = (bus.keycode == FIRE_KEY);
`else
  assign w_fire_req = (bus.keycode == FIRE_KEY) && (r_prev_key != FIRE_KEY);
`endif

  // Lowest-index idle slot, judged on this frame's pre-update state.
  always_comb begin
    w_first_idle = '0;
    w_any_idle   = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (w_idle[i] && !w_any_idle) begin
        w_first_idle[i] = 1'b1;
        w_any_idle      = 1'b1;
      end
    end
  end

  assign w_launch     = w_fire_req && (r_cooldown == '0) && w_any_idle;
  assign w_launch_vec = w_launch ? w_first_idle : '0;
  assign w_launch_y   = sat_sub10(bus.ShipY, bus.ShipSY);

  // Key history, launch cooldown down-counter and the registered fire pulse.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_prev_key   <= '0;
      r_cooldown   <= '0;
      r_fire_pulse <= 1'b0;
    end else begin
      r_prev_key   <= bus.keycode;
      r_fire_pulse <= w_launch;
      if (w_launch)              r_cooldown <= CD_LOAD;
      else if (r_cooldown != '0) r_cooldown <= r_cooldown - 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
    assign w_hit_vec[gi] = bus.hit_valid && (bus.hit_idx == 3'(gi));

    shot_slot #(.SHOT_STEP(SHOT_STEP)) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .i_launch   (w_launch_vec[gi]),
      .i_launch_x (bus.ShipX),
      .i_launch_y (w_launch_y),
      .i_hit      (w_hit_vec[gi]),
      .o_shot     (w_shot[gi])
    );

    assign w_idle[gi]            = ~w_shot[gi].active;
    assign bus.ShotActive[gi]    = w_shot[gi].active;
    assign bus.ShotX[10*gi +: 10] = w_shot[gi].x;
    assign bus.ShotY[10*gi +: 10] = w_shot[gi].y;
  end

  assign bus.fire_pulse = r_fire_pulse;

endmodule

// File: doc/ship_shot_ctrl.md
# ship_shot_ctrl

Player-shot manager directly downstream of the spaceship stage. Each frame it consumes the ship's registered position and size plus the keyboard keycode, launches shots from the ship's nose on the fire key, advances every live shot upward, and retires shots that leave the screen or are reported hit. Its shot positions feed the color mapper and the enemy-collision logic.

## Interface
- NUM_SHOTS, 4: shot slots in the pool (1-8)
- SHOT_STEP, 4: pixels a live shot moves up per frame
- COOLDOWN, 8: frames after a launch before the next launch is allowed
- frame_clk  in  1  frame-rate clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock, no other clock domains
- keycode  in  8  current USB keycode
- ShipX  in  10  ship center X
- ShipY  in  10  ship center Y
- ShipSY  in  10  ship half-height
- hit_valid  in  1  collision logic reports a hit this frame
- hit_idx  in  3  slot index of the hit shot (only low bits used)
- ShotX  out  10*NUM_SHOTS  packed shot X, slot i at [10i+9:10i]
- ShotY  out  10*NUM_SHOTS  packed shot Y, same packing
- ShotActive  out  NUM_SHOTS  slot i holds a live shot
- fire_pulse  out  1  high for exactly the frame in which a launch occurred

## Operation
- Per-slot state: IDLE or FLY. Reset: all slots IDLE, ShotX/ShotY 0, ShotActive 0, fire_pulse 0, cooldown 0, previous-key register 0.
- Fire request: keycode == FIRE_KEY (8'h2C, space) and previous-frame keycode != FIRE_KEY (rising edge).
- Launch when fire request, cooldown == 0, and at least one slot IDLE: choose lowest-index IDLE slot, set FLY, ShotX = ShipX, ShotY = ShipY - ShipSY saturated at 0; load cooldown = COOLDOWN; fire_pulse = 1.
- Request with no free slot or cooldown > 0 is dropped, not queued; cooldown not reloaded.
- Cooldown decrements by 1 each frame while nonzero, saturates at 0.
- FLY slot each frame: if hit_valid and hit_idx == slot -> IDLE; else if ShotY < SHOT_STEP -> IDLE (retire at top edge, no wrap); else ShotY -= SHOT_STEP. ShotX constant during flight.
- Priority per slot: hit > retire > move. hit_valid on an IDLE slot or hit_idx >= NUM_SHOTS: ignored.
- Free-slot search uses pre-update state: a slot freed this frame is reusable next frame, never same frame.
- Newly launched shot does not move in its launch frame.
- IDLE slots hold last ShotX/ShotY; consumers must qualify with ShotActive.
- All 10-bit arithmetic unsigned; no negative positions exist.

## Timing
- All outputs registered; one frame_clk latency from keycode edge to ShotActive/fire_pulse.
- Hit input to ShotActive deassert: one frame.
- Reset asserted mid-flight clears all slots on that edge; first launch possible on the first frame after Reset deasserts, provided the key edge occurs then.
- Minimum launch spacing: COOLDOWN+1 frames.

## Configuration
- SHIP_SHOT_AUTOFIRE_EN defined: fire request is keycode == FIRE_KEY (level); holding space launches every COOLDOWN+1 frames while a slot is free.
- Undefined: rising-edge requirement as above; holding space launches once.

## Structure
- Shared package ship_pkg: FIRE_KEY, SCREEN_W/SCREEN_H, shot state enum (IDLE, FLY), shot_t struct {active, x, y}.
- Sub-module shot_slot: one per slot, holds state/x/y, inputs launch, launch_x, launch_y, hit; controller does edge detect, cooldown, priority allocation.

## Test plan
- Reset, ShipX=320, ShipY=360, ShipSY=25, keycode 0->2C: next frame slot 0 FLY at (320,335), fire_pulse=1 one frame; following frame Y=331.
- Hold 2C for 20 frames (macro off): exactly one launch; macro on: launches at frames 0, 9, 18 (COOLDOWN=8).
- Four launches spaced >8 frames, fifth request with all slots live: dropped, fire_pulse 0, cooldown unchanged.
- Shot at Y=3 with SHOT_STEP=4: retires next frame, ShotActive bit 0, no wrap to 1023.
- hit_valid with hit_idx=1 while slot 1 FLY and a launch in the same frame: slot 1 IDLE, launch goes to lowest free slot other than 1.
- Reset asserted with three shots live: all ShotActive 0, cooldown 0 on that edge.
